data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between the CPU datapath and the data memory responder.
// Both directions use valid/ready; the responder takes the slave modport.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed 16-bit data memory; one request in flight, responds WAIT_CYCLES+1 cycles after acceptance.
// Backpressure: req_ready only in IDLE; response held until resp_ready. Define DMEM_ALIGN_CHECK_EN to fault odd addresses.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    data_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         CNT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [15:0] mem [2**ADDR_W];

    logic              cur_we;
    logic [15:0]       cur_addr;
    logic [15:0]       cur_wdata;
    logic [ADDR_W-1:0] cur_idx;
    logic              cur_fault;
    logic              commit;
    logic              mem_we;

    // With zero wait states the commit happens on the acceptance edge, so the live inputs are used.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end
        cur_idx   = cur_addr[ADDR_W:1];
        cur_fault = (cur_addr >> (ADDR_W + 1)) != 16'd0;
`ifdef DMEM_ALIGN_CHECK_EN
        cur_fault = cur_fault | cur_addr[0];
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 16'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            err_d   = cur_fault;
            rdata_d = (!cur_fault && !cur_we) ? mem[cur_idx] : 16'd0;
        end
        // A request presented while reset is held must not reach the array.
        mem_we = commit && !cur_fault && cur_we && resetn;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 has no wait states, instance 1 has one.
// Expectations come from a word-array model of memory and the address fault rules.
module tb_data_mem_responder;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int WC0 = 0;
    localparam int WC1 = 1;

    logic clk;
    logic rst_n;

    data_mem_responder_if b0 ();
    data_mem_responder_if b1 ();

    logic        rv  [2];
    logic        rwe [2];
    logic [15:0] ra  [2];
    logic [15:0] rwd [2];
    logic        rr  [2];
    logic        q_rdy [2];
    logic        s_vld [2];
    logic        s_err [2];
    logic [15:0] s_dat [2];

    assign b0.req_valid  = rv[0];
    assign b0.req_we     = rwe[0];
    assign b0.req_addr   = ra[0];
    assign b0.req_wdata  = rwd[0];
    assign b0.resp_ready = rr[0];
    assign b1.req_valid  = rv[1];
    assign b1.req_we     = rwe[1];
    assign b1.req_addr   = ra[1];
    assign b1.req_wdata  = rwd[1];
    assign b1.resp_ready = rr[1];
    assign q_rdy[0] = b0.req_ready;
    assign s_vld[0] = b0.resp_valid;
    assign s_err[0] = b0.resp_err;
    assign s_dat[0] = b0.resp_rdata;
    assign q_rdy[1] = b1.req_ready;
    assign s_vld[1] = b1.resp_valid;
    assign s_err[1] = b1.resp_err;
    assign s_dat[1] = b1.resp_rdata;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(WC0)) u_dut0 (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (b0)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(WC1)) u_dut1 (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mdl   [2][1024];
    bit          known [2][1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input int s);
        chk({tag, "_rdy"}, 32'(q_rdy[s]), 32'd1);
        chk({tag, "_vld"}, 32'(s_vld[s]), 32'd0);
        chk({tag, "_dat"}, 32'(s_dat[s]), 32'd0);
        chk({tag, "_err"}, 32'(s_err[s]), 32'd0);
    endtask

    // One full request/response exchange on instance s, checked against the memory model.
    task automatic txn(input int s, input bit we, input logic [15:0] addr, input logic [15:0] wd,
                       input int hold, input bit early,
                       output logic [15:0] got_d, output logic got_e);
        int          lat;
        int          idx;
        int          wc;
        bit          exp_err;
        bit          chk_d;
        logic [15:0] exp_d;
        logic [31:0] junk;
        wc      = (s == 0) ? WC0 : WC1;
        exp_err = (int'(addr) >= 2048) || (ALIGN && (int'(addr) % 2 == 1));
        idx     = (int'(addr) / 2) % 1024;
        chk_d   = 1'b1;
        exp_d   = 16'd0;
        if (!exp_err && we) begin
            mdl[s][idx]   = wd;
            known[s][idx] = 1'b1;
        end else if (!exp_err) begin
            chk_d = known[s][idx];
            exp_d = mdl[s][idx];
        end
        rv[s] = 1'b1; rwe[s] = we; ra[s] = addr; rwd[s] = wd;
        chk("req_ready_idle", 32'(q_rdy[s]), 32'd1);
        step();
        // Scramble the request lines: the captured request must be what gets served.
        junk = $urandom;
        rv[s] = 1'b0; rwe[s] = junk[0]; ra[s] = junk[31:16]; rwd[s] = junk[15:0];
        rr[s] = early;
        // lat = edge, counted from the acceptance edge, at which resp_valid is first sampled high
        lat = 1;
        while (!s_vld[s] && lat < 40) begin
            chk("req_ready_wait", 32'(q_rdy[s]), 32'd0);
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(wc + 1));
        got_d = s_dat[s];
        got_e = s_err[s];
        chk("resp_err", 32'(got_e), 32'(exp_err));
        if (chk_d) chk("resp_rdata", 32'(got_d), 32'(exp_d));
        chk("req_ready_resp", 32'(q_rdy[s]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_vld", 32'(s_vld[s]), 32'd1);
            chk("hold_out", {15'd0, s_err[s], s_dat[s]}, {15'd0, got_e, got_d});
            chk("hold_rdy", 32'(q_rdy[s]), 32'd0);
        end
        rr[s] = 1'b1;
        step();
        rr[s] = 1'b0;
        chk("resp_done", {30'd0, s_vld[s], q_rdy[s]}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic        e;
        logic [31:0] r;
        int          h;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rwe[i] = 1'b0; ra[i] = 16'd0; rwd[i] = 16'd0; rr[i] = 1'b0;
        end
        rst_n = 1'b0;
        step();
        step();
        chk_idle("rst_held0", 0);
        chk_idle("rst_held1", 1);
        rst_n = 1'b1;
        step();
        chk_idle("rst_rel0", 0);
        chk_idle("rst_rel1", 1);

        // Store then load, one wait state.
        txn(1, 1'b1, 16'h0004, 16'h00AB, 0, 1'b0, d, e);
        chk("st_0004_rdata", 32'(d), 32'd0);
        txn(1, 1'b0, 16'h0004, 16'h0000, 0, 1'b0, d, e);
        chk("ld_0004", 32'(d), 32'h00AB);

        // Zero wait states.
        txn(0, 1'b1, 16'h0010, 16'h1234, 0, 1'b0, d, e);
        txn(0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, d, e);
        chk("ld0_0010", 32'(d), 32'h1234);

        // Out-of-range accesses; 0x0800 would alias word 0 if it were not rejected.
        txn(1, 1'b1, 16'h0000, 16'h5A5A, 0, 1'b0, d, e);
        txn(1, 1'b0, 16'h0800, 16'h0000, 0, 1'b0, d, e);
        chk("ld_0800_err", 32'(e), 32'd1);
        txn(1, 1'b1, 16'h0800, 16'h1111, 0, 1'b0, d, e);
        chk("st_0800_err", 32'(e), 32'd1);
        txn(1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, d, e);
        chk("ld_0000_kept", 32'(d), 32'h5A5A);
        txn(1, 1'b0, 16'hFFFE, 16'h0000, 0, 1'b0, d, e);
        chk("ld_FFFE_err", 32'(e), 32'd1);
        txn(1, 1'b0, 16'hFFFF, 16'h0000, 0, 1'b1, d, e);
        chk("ld_FFFF_err", 32'(e), 32'd1);

        // Odd address handling.
        txn(1, 1'b1, 16'h0002, 16'h2222, 0, 1'b0, d, e);
        txn(1, 1'b1, 16'h0003, 16'h7777, 0, 1'b0, d, e);
        chk("st_0003_err", 32'(e), 32'(ALIGN));
        txn(1, 1'b0, 16'h0002, 16'h0000, 0, 1'b0, d, e);
        chk("ld_0002", 32'(d), ALIGN ? 32'h2222 : 32'h7777);

        // Response held off for five cycles.
        txn(1, 1'b1, 16'h0040, 16'h0F0F, 0, 1'b0, d, e);
        txn(1, 1'b0, 16'h0040, 16'h0000, 5, 1'b0, d, e);
        chk("ld_0040_held", 32'(d), 32'h0F0F);

        // Reset while a store is waiting: the store must be dropped.
        txn(1, 1'b1, 16'h0020, 16'h0000, 0, 1'b0, d, e);
        rv[1] = 1'b1; rwe[1] = 1'b1; ra[1] = 16'h0020; rwd[1] = 16'hBEEF;
        step();
        rv[1] = 1'b0;
        chk("beef_in_wait", {30'd0, s_vld[1], q_rdy[1]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_idle("rst_mid_wait", 1);
        step();
        rst_n = 1'b1;
        step();
        txn(1, 1'b0, 16'h0020, 16'h0000, 0, 1'b0, d, e);
        chk("ld_0020_no_beef", 32'(d), 32'h0000);

        // Randomized traffic on both instances.
        for (int n = 0; n < 80; n++) begin
            int s;
            s = int'($urandom_range(0, 1));
            r = $urandom;
            h = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
                txn(s, r[0], r[31:16], r[15:0], h, (h == 0) && r[1], d, e);
            else
                txn(s, r[0], 16'($urandom_range(0, 127)), r[15:0], h, (h == 0) && r[1], d, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
